// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
// word_t and regbits_t describe the default 32 x 32-bit register file shape.
// Register files built with other widths use local parameters instead.
package cpu_types_pkg;

  localparam int WORD_W    = 32;
  localparam int REG_COUNT = 32;
  localparam int REGBITS_W = $clog2(REG_COUNT);

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REGBITS_W-1:0] regbits_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file.
// Each register has one busy bit. The bit is set when an instruction that
// writes that register issues, and it is cleared when the register is
// written back.
// Ports:
//   CLK, nRST  clock; asynchronous active-low reset
//   issue_en   set the busy bit of issue_sel at the next edge
//   issue_sel  destination register of the issuing instruction
//   clr        one bit per register; written back this cycle
//   flush      clear every busy bit; takes priority over issue_en
//   busy_vec   current busy bits (bit 0 is always 0)
module regfile_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_sel,
  input  logic [NREGS-1:0] clr,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] set;
  logic [NREGS-1:0] busy;

  always_comb begin
    set = '0;
    if (issue_en && (issue_sel != '0)) set[issue_sel] = 1'b1;
  end

  // The set is applied after the clear. An issue and a write-back to the
  // same register in one cycle therefore leave the bit set, because the
  // newer producer is still in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)      busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= (busy & ~clr) | set;
  end

  assign busy_vec = busy;

endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-port register file with a RAW-hazard scoreboard.
// Register 0 always reads as zero, is never busy, and ignores writes and
// issues. Reads are combinational. When BYPASS=1, write data from the
// current cycle is forwarded to the read ports.
// Ports:
//   CLK, nRST           clock; asynchronous active-low reset
//   rsel, rvalid        per-read-port register select and "operand used"
//   rdat, rbusy         per-read-port data and pending-producer flag
//   hazard              some used operand still waits for its producer
//   WEN, wsel, wdat     per-write-port enable, register select and data
//   issue_en, issue_sel mark a destination register as pending
//   flush               clear all pending marks
//   busy_vec            raw scoreboard bits
module scoreboard_register_file
  import cpu_types_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int WIDTH  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NREAD-1:0][AW-1:0]     rsel,
  input  logic [NREAD-1:0]             rvalid,
  output logic [NREAD-1:0][WIDTH-1:0]  rdat,
  output logic [NREAD-1:0]             rbusy,
  output logic                         hazard,
  input  logic [NWRITE-1:0]            WEN,
  input  logic [NWRITE-1:0][AW-1:0]    wsel,
  input  logic [NWRITE-1:0][WIDTH-1:0] wdat,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_sel,
  input  logic                         flush,
  output logic [NREGS-1:0]             busy_vec
);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            clr;

  // The write ports are visited in ascending order. When two ports select
  // the same register, the last nonblocking assignment (port NWRITE-1)
  // takes effect. Register 0 is never written, so it stays zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      regs <= '0;
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (WEN[w] && (wsel[w] != '0)) regs[wsel[w]] <= wdat[w];
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int w = 0; w < NWRITE; w++) begin
      if (WEN[w]) clr[wsel[w]] = 1'b1;
    end
    clr[0] = 1'b0;
  end

  regfile_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .CLK       (CLK),
    .nRST      (nRST),
    .issue_en  (issue_en),
    .issue_sel (issue_sel),
    .clr       (clr),
    .flush     (flush),
    .busy_vec  (busy_vec)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [WIDTH-1:0] rd;
    logic             rb;

    // A same-cycle write forwards its data, and the register counts as
    // not busy: the producer is completing in this cycle. The
    // highest-index matching write port wins.
    always_comb begin
      rd = regs[rsel[i]];
      rb = busy_vec[rsel[i]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWRITE; w++) begin
          if (WEN[w] && (wsel[w] == rsel[i]) && (rsel[i] != '0)) begin
            rd = wdat[w];
            rb = 1'b0;
          end
        end
      end
    end

    assign rdat[i]  = rd;
    assign rbusy[i] = rb;
  end

  assign hazard = |(rvalid & rbusy);

endmodule

// File: tb/tb_scoreboard_register_file.sv
module tb_scoreboard_register_file;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][4:0]  rsel;
  logic [1:0]       rvalid;
  logic [1:0]       wen;
  logic [1:0][4:0]  wsel;
  logic [1:0][31:0] wdat;
  logic             issue_en;
  logic [4:0]       issue_sel;
  logic             flush;

  // dut: two write ports with bypass. dutz: one write port without bypass
  // (it sees only write port 0).
  logic [1:0][31:0] m_rdat, z_rdat;
  logic [1:0]       m_rbusy, z_rbusy;
  logic             m_haz, z_haz;
  logic [31:0]      m_bv, z_bv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scoreboard_register_file #(.NWRITE(2), .BYPASS(1)) dut (
    .CLK(clk), .nRST(rst_n), .rsel(rsel), .rvalid(rvalid), .rdat(m_rdat),
    .rbusy(m_rbusy), .hazard(m_haz), .WEN(wen), .wsel(wsel), .wdat(wdat),
    .issue_en(issue_en), .issue_sel(issue_sel), .flush(flush), .busy_vec(m_bv)
  );

  scoreboard_register_file #(.NWRITE(1), .BYPASS(0)) dutz (
    .CLK(clk), .nRST(rst_n), .rsel(rsel), .rvalid(rvalid), .rdat(z_rdat),
    .rbusy(z_rbusy), .hazard(z_haz), .WEN(wen[0:0]), .wsel(wsel[0:0]),
    .wdat(wdat[0:0]), .issue_en(issue_en), .issue_sel(issue_sel),
    .flush(flush), .busy_vec(z_bv)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rsel = '0; rvalid = '0; wen = '0; wsel = '0; wdat = '0;
    issue_en = 1'b0; issue_sel = '0; flush = 1'b0;
  endtask

  // Directed vectors. Expected values are taken before the clock edge of
  // each row. Column z_* is for the no-bypass single-write-port instance.
  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  ws0, ws1;
    word_t       wd0, wd1;
    logic        ie;
    logic [4:0]  isel;
    logic        fl;
    logic [4:0]  rs0, rs1;
    logic [1:0]  rv;
    word_t       m_rd0, m_rd1;
    logic        m_hz;
    logic [31:0] bv;
    word_t       z_rd0;
    logic        z_hz;
  } vec_t;

  vec_t vecs[11];

  // Reference model: the architectural state of each instance.
  word_t mem_m[32], mem_z[32];
  bit    busy_m[32], busy_z[32];

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mem_m[r] = '0; mem_z[r] = '0; busy_m[r] = 0; busy_z[r] = 0;
    end
  endtask

  // Apply the current inputs as a clock edge: completing writes clear busy,
  // then an issue sets it. A flush clears everything.
  task automatic model_edge();
    for (int w = 0; w < 2; w++) begin
      if (wen[w] && wsel[w] != 0) begin
        mem_m[wsel[w]] = wdat[w];
        busy_m[wsel[w]] = 0;
        if (w == 0) begin
          mem_z[wsel[w]] = wdat[w];
          busy_z[wsel[w]] = 0;
        end
      end
    end
    if (flush) begin
      for (int r = 0; r < 32; r++) begin busy_m[r] = 0; busy_z[r] = 0; end
    end else if (issue_en && issue_sel != 0) begin
      busy_m[issue_sel] = 1; busy_z[issue_sel] = 1;
    end
  endtask

  task automatic model_check();
    word_t       ed;
    bit          eb;
    bit          eh_m, eh_z;
    logic [31:0] ebv_m, ebv_z;
    eh_m = 0; eh_z = 0;
    for (int i = 0; i < 2; i++) begin
      // Instance with bypass: the newest matching write supplies the data.
      ed = mem_m[rsel[i]]; eb = busy_m[rsel[i]];
      if (rsel[i] != 0) begin
        for (int w = 0; w < 2; w++) begin
          if (wen[w] && wsel[w] == rsel[i]) begin ed = wdat[w]; eb = 0; end
        end
      end else begin
        ed = 0; eb = 0;
      end
      chk($sformatf("rand_m_rdat%0d", i), m_rdat[i], ed);
      chk($sformatf("rand_m_rbusy%0d", i), m_rbusy[i], eb);
      eh_m |= eb & rvalid[i];
      // Instance without bypass: only registered state is visible.
      ed = (rsel[i] == 0) ? 0 : mem_z[rsel[i]];
      eb = (rsel[i] == 0) ? 0 : busy_z[rsel[i]];
      chk($sformatf("rand_z_rdat%0d", i), z_rdat[i], ed);
      chk($sformatf("rand_z_rbusy%0d", i), z_rbusy[i], eb);
      eh_z |= eb & rvalid[i];
    end
    for (int r = 0; r < 32; r++) begin ebv_m[r] = busy_m[r]; ebv_z[r] = busy_z[r]; end
    chk("rand_m_hazard", m_haz, eh_m);
    chk("rand_z_hazard", z_haz, eh_z);
    chk("rand_m_busy_vec", m_bv, ebv_m);
    chk("rand_z_busy_vec", z_bv, ebv_z);
  endtask

  initial begin
    //            wen    ws0 ws1 wd0          wd1      ie isel fl rs0 rs1 rv     m_rd0        m_rd1        hz bv          z_rd0        z_hz
    vecs[0]  = '{2'b01, 3,  0,  32'h12345678, 0,       0, 0,  0, 3,  0,  2'b00, 32'h12345678, 0,           0, 0,          0,           0};
    vecs[1]  = '{2'b11, 7,  7,  32'hAAAA,     32'hBBBB,0, 0,  0, 7,  3,  2'b00, 32'hBBBB,     32'h12345678,0, 0,          0,           0};
    vecs[2]  = '{2'b00, 0,  0,  0,            0,       1, 9,  0, 7,  3,  2'b00, 32'hBBBB,     32'h12345678,0, 0,          32'hAAAA,    0};
    vecs[3]  = '{2'b00, 0,  0,  0,            0,       0, 0,  0, 7,  9,  2'b10, 32'hBBBB,     0,           1, 32'h200,    32'hAAAA,    1};
    vecs[4]  = '{2'b01, 9,  0,  32'h55,       0,       0, 0,  0, 7,  9,  2'b10, 32'hBBBB,     32'h55,      0, 32'h200,    32'hAAAA,    1};
    vecs[5]  = '{2'b10, 0,  4,  0,            32'h44,  1, 4,  0, 9,  4,  2'b11, 32'h55,       32'h44,      0, 0,          32'h55,      0};
    vecs[6]  = '{2'b00, 0,  0,  0,            0,       0, 0,  0, 4,  0,  2'b01, 32'h44,       0,           1, 32'h10,     0,           1};
    vecs[7]  = '{2'b00, 0,  0,  0,            0,       1, 6,  1, 4,  0,  2'b01, 32'h44,       0,           1, 32'h10,     0,           1};
    vecs[8]  = '{2'b00, 0,  0,  0,            0,       0, 0,  0, 6,  4,  2'b11, 0,            32'h44,      0, 0,          0,           0};
    vecs[9]  = '{2'b01, 0,  0,  32'hFFFF,     0,       1, 0,  0, 0,  0,  2'b11, 0,            0,           0, 0,          0,           0};
    vecs[10] = '{2'b00, 0,  0,  0,            0,       0, 0,  0, 0,  0,  2'b11, 0,            0,           0, 0,          0,           0};

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_rdat", m_rdat, 64'h0);
    chk("reset_m_hazard", m_haz, 1'b0);
    chk("reset_m_busy_vec", m_bv, 32'h0);
    chk("reset_z_busy_vec", z_bv, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 11; k++) begin
      wen = vecs[k].wen; wsel[0] = vecs[k].ws0; wsel[1] = vecs[k].ws1;
      wdat[0] = vecs[k].wd0; wdat[1] = vecs[k].wd1;
      issue_en = vecs[k].ie; issue_sel = vecs[k].isel; flush = vecs[k].fl;
      rsel[0] = vecs[k].rs0; rsel[1] = vecs[k].rs1; rvalid = vecs[k].rv;
      #4;
      chk($sformatf("vec%0d_m_rdat0", k), m_rdat[0], vecs[k].m_rd0);
      chk($sformatf("vec%0d_m_rdat1", k), m_rdat[1], vecs[k].m_rd1);
      chk($sformatf("vec%0d_m_hazard", k), m_haz, vecs[k].m_hz);
      chk($sformatf("vec%0d_m_busy_vec", k), m_bv, vecs[k].bv);
      chk($sformatf("vec%0d_z_rdat0", k), z_rdat[0], vecs[k].z_rd0);
      chk($sformatf("vec%0d_z_hazard", k), z_haz, vecs[k].z_hz);
      chk($sformatf("vec%0d_z_busy_vec", k), z_bv, vecs[k].bv);
      @(posedge clk); #1;
    end

    // Asynchronous reset between clock edges: issue and write r5 together,
    // so r5 holds data and stays busy. Then pulse nRST mid-cycle.
    idle();
    wen = 2'b01; wsel[0] = 5; wdat[0] = 32'hDEADBEEF; issue_en = 1'b1; issue_sel = 5;
    @(posedge clk); #1;
    idle();
    rsel[0] = 5; rvalid = 2'b01;
    #2;
    chk("pre_reset_m_rdat0", m_rdat[0], 32'hDEADBEEF);
    chk("pre_reset_z_rdat0", z_rdat[0], 32'hDEADBEEF);
    chk("pre_reset_busy_vec", m_bv, 32'h20);
    rst_n = 1'b0;
    #1;
    chk("async_reset_m_rdat0", m_rdat[0], 32'h0);
    chk("async_reset_z_rdat0", z_rdat[0], 32'h0);
    chk("async_reset_m_busy_vec", m_bv, 32'h0);
    chk("async_reset_z_busy_vec", z_bv, 32'h0);
    chk("async_reset_hazard", m_haz, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    model_reset();

    // Random traffic on a small register window so that hits are frequent.
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < 2; w++) begin
        wen[w]  = ($urandom_range(0, 2) == 0);
        wsel[w] = 5'($urandom_range(0, 7));
        wdat[w] = $urandom;
      end
      for (int i = 0; i < 2; i++) rsel[i] = 5'($urandom_range(0, 7));
      rvalid    = 2'($urandom_range(0, 3));
      issue_en  = ($urandom_range(0, 1) == 1);
      issue_sel = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 15) == 0);
      #4;
      model_check();
      model_edge();
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
